cbus_arbiter: RTL

Two-master to one-slave arbiter for cache-line bus traffic, sitting directly downstream of the instruction-side and data-side caches (including the DCache inside the MMU) and upstream of the CBus-to-AXI bridge. Grants one complete burst transaction at a time with round-robin fairness. Forwards the granted master's request to memory and routes the memory response back to that master only. Checks beat counts against the requested burst length and latches a sticky protocol-error flag on mismatch.

---
 rtl/cbus_pkg.sv | 20 ++
 rtl/cbus_arbiter_if.sv | 23 ++
 rtl/cbus_arbiter.sv | 109 ++++++++++
 3 files changed

// File: rtl/cbus_pkg.sv
// Cache-bus request/response types shared by the caches, the arbiter and the AXI bridge.
package cbus_pkg;

    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [3:0]  strobe;
        logic [31:0] data;
        logic [3:0]  len;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [31:0] data;
    } cbus_resp_t;

endpackage

// File: rtl/cbus_arbiter_if.sv
// Bundle of the two cache ports and the memory-bridge port around cbus_arbiter.
interface cbus_arbiter_if;
    import cbus_pkg::*;

    cbus_req_t  icreq;
    cbus_req_t  dcreq;
    cbus_resp_t icresp;
    cbus_resp_t dcresp;
    cbus_req_t  oreq;
    cbus_resp_t oresp;

    // master: the surrounding caches and bridge; slave: the arbiter itself
    modport master (
        output icreq, dcreq, oresp,
        input  icresp, dcresp, oreq
    );

    modport slave (
        input  icreq, dcreq, oresp,
        output icresp, dcresp, oreq
    );

endinterface

// File: rtl/cbus_arbiter.sv
// Round-robin two-master arbiter granting whole bursts to one memory bridge,
// with a sticky protocol-error flag for beat-count mismatches and stray responses.
module cbus_arbiter
    import cbus_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    cbus_arbiter_if.slave bus,
    output logic          protocol_err
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t     state_r;
    logic       owner_r;
    logic       last_owner_r;
    logic [4:0] beat_cnt_r;
    logic [3:0] len_q_r;
    logic       protocol_err_r;

    logic       grant_vld_s;
    logic       grant_d_s;
    logic       at_len_s;

    // Winner selection: a tie goes to whichever master did not own the previous burst
    always_comb begin
        grant_vld_s = bus.icreq.valid | bus.dcreq.valid;
        at_len_s    = (beat_cnt_r == {1'b0, len_q_r});
        if (bus.icreq.valid && bus.dcreq.valid) begin
            grant_d_s = ~last_owner_r;
        end else if (bus.dcreq.valid) begin
            grant_d_s = 1'b1;
        end else begin
            grant_d_s = 1'b0;
        end
    end

    // Combinational passthrough of the owner's request and the bridge response
    always_comb begin
        bus.oreq   = '0;
        bus.icresp = '0;
        bus.dcresp = '0;
        if (state_r == ST_BUSY) begin
            if (owner_r) begin
                bus.oreq   = bus.dcreq;
                bus.dcresp = bus.oresp;
            end else begin
                bus.oreq   = bus.icreq;
                bus.icresp = bus.oresp;
            end
        end else begin
            bus.oreq   = '0;
            bus.icresp = '0;
            bus.dcresp = '0;
        end
    end

    // Arbitration FSM, beat counting and sticky error flag
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r        <= ST_IDLE;
            owner_r        <= 1'b0;
            last_owner_r   <= 1'b1;
            beat_cnt_r     <= 5'd0;
            len_q_r        <= 4'd0;
            protocol_err_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.oresp.ready || bus.oresp.last) begin
                        protocol_err_r <= 1'b1;
                    end
                    if (grant_vld_s) begin
                        owner_r    <= grant_d_s;
                        len_q_r    <= grant_d_s ? bus.dcreq.len : bus.icreq.len;
                        beat_cnt_r <= 5'd0;
                        state_r    <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (bus.oresp.ready) begin
                        // saturate so a runaway overrun cannot wrap back onto len_q
                        if (beat_cnt_r != 5'd31) begin
                            beat_cnt_r <= beat_cnt_r + 5'd1;
                        end
                        if (bus.oresp.last) begin
                            if (!at_len_s) begin
                                protocol_err_r <= 1'b1;
                            end
                            last_owner_r <= owner_r;
                            state_r      <= ST_IDLE;
                        end else if (at_len_s) begin
                            protocol_err_r <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign protocol_err = protocol_err_r;

endmodule
